// File: rtl/mem_access_unit_pkg.sv
// Shared types and encoders for the memory-stage load/store unit:
// size codes, FSM states, latched-op record and byte-lane helpers.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef struct packed {
        logic       is_load;
        logic       is_fp;
        logic       is_lr;
        logic       is_sc;
        logic [2:0] funct3;
        logic [1:0] off;
    } op_t;

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return BE_B << off;
            2'b01:   return BE_H << {off[1], 1'b0};
            default: return BE_W;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus req/ack interface between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/half lane of a read word and sign- or zero-extends it.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{off_i, 3'b000} +: 8];
    assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns EX/MEM control into a req/ack bus access,
// stalls the pipeline while it is outstanding, and tracks the LR/SC reservation.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        FPMemM,
    input  logic        LrM,
    input  logic        ScM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] FP_WriteDataM,
    input  logic        ResInvalidate,
    input  logic [31:0] ResInvAddr,
    mem_access_unit_if.master dmem,
    output logic [31:0] ReadDataM,
    output logic [31:0] FP_ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    op_t         op_q;
    logic [31:0] addr_q, wdata_q, rd_q, fp_q;
    logic [3:0]  be_q;
    logic        we_q, bus_err_q;
    logic        res_valid_q;
    logic [29:0] res_addr_q;

    logic        access, misalign, res_hit, in_idle, sc_fail, start, timeout;
    logic        lr_set, inv_new, inv_cur;
    logic [2:0]  eff_f3;
    logic [1:0]  off;
    logic [31:0] load_data;
    logic        unused_inv_bits;

    // FP, LR and SC accesses are always full words whatever Funct3M says
    assign access   = MemReadM | MemWriteM | LrM | ScM;
    assign eff_f3   = (FPMemM | LrM | ScM) ? F3_W : Funct3M;
    assign off      = ALU_ResultM[1:0];
    assign misalign = access && misaligned(eff_f3, off);
    assign res_hit  = res_valid_q && (res_addr_q == ALU_ResultM[31:2]);
    assign in_idle  = (state_q == IDLE);
    assign sc_fail  = in_idle && ScM && !misalign && !res_hit;
    assign start    = in_idle && access && !misalign && !(ScM && !res_hit);
    assign timeout  = (state_q == REQ) && !dmem.dmem_ack && (count_q == TIMEOUT_LAST);

    assign lr_set   = (state_q == REQ) && dmem.dmem_ack && op_q.is_lr;
    assign inv_new  = ResInvalidate && (ResInvAddr[31:2] == addr_q[31:2]);
    assign inv_cur  = ResInvalidate && (ResInvAddr[31:2] == res_addr_q);
    assign unused_inv_bits = ^ResInvAddr[1:0];

    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    mem_access_unit_load_align u_align (
        .word_i   (dmem.dmem_rdata),
        .off_i    (op_q.off),
        .funct3_i (op_q.funct3),
        .data_o   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (start) state_d = REQ;
            end
            REQ: begin
                if (dmem.dmem_ack || timeout) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        StallM        = 1'b0;
        MisalignM     = 1'b0;
        BusErrM       = 1'b0;
        dmem.dmem_req = 1'b0;
        case (state_q)
            IDLE: begin
                StallM    = start;
                MisalignM = misalign;
            end
            REQ: begin
                StallM        = 1'b1;
                dmem.dmem_req = 1'b1;
            end
            DONE:    BusErrM = bus_err_q;
            default: ;
        endcase
        // A failing SC answers in the same cycle without touching the bus
        ReadDataM    = sc_fail ? 32'd1 : rd_q;
        FP_ReadDataM = fp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            fp_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (start) begin
                addr_q    <= {ALU_ResultM[31:2], 2'b00};
                we_q      <= MemWriteM | ScM;
                be_q      <= byte_enables(eff_f3, off);
                wdata_q   <= FPMemM ? FP_WriteDataM : store_data(eff_f3, WriteDataM);
                op_q      <= '{is_load: MemReadM | LrM, is_fp: FPMemM, is_lr: LrM,
                               is_sc: ScM, funct3: eff_f3, off: off};
                bus_err_q <= 1'b0;
            end
            if (sc_fail) rd_q <= 32'd1;
            if (state_q == REQ) begin
                if (dmem.dmem_ack) begin
                    if (op_q.is_load && op_q.is_fp) begin
                        fp_q <= load_data;
                        rd_q <= '0;
                    end else if (op_q.is_load) begin
                        rd_q <= load_data;
                    end else if (op_q.is_sc) begin
                        rd_q <= '0;
                    end
                end else if (timeout) begin
                    bus_err_q <= 1'b1;
                    rd_q      <= '0;
                    fp_q      <= '0;
                end
            end
        end
    end

    // A snoop hitting the word an LR is completing on beats the new reservation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
        end else if (lr_set) begin
            res_valid_q <= !inv_new;
            res_addr_q  <= addr_q[31:2];
        end else if (inv_cur || (in_idle && ScM) || (start && MemWriteM && res_hit)) begin
            res_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus LR/SC, snoop and reset sequences.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM, FPMemM, LrM, ScM, ResInvalidate;
    logic [2:0]  Funct3M;
    logic [31:0] ALU_ResultM, WriteDataM, FP_WriteDataM, ResInvAddr;
    logic [31:0] ReadDataM, FP_ReadDataM;
    logic        StallM, MisalignM, BusErrM;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .FPMemM(FPMemM),
        .LrM(LrM), .ScM(ScM), .Funct3M(Funct3M), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM), .FP_WriteDataM(FP_WriteDataM),
        .ResInvalidate(ResInvalidate), .ResInvAddr(ResInvAddr),
        .dmem(bus),
        .ReadDataM(ReadDataM), .FP_ReadDataM(FP_ReadDataM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd, wr, fp, lr, sc;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, fpwdata, rdata;
        int          ack_dly;
        logic        early, exp_mis, exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_stall;
        logic        exp_bus, chk_rd, chk_fp;
        logic [31:0] exp_rd, exp_fp;
    } vec_t;

    vec_t        exp_q[$];
    vec_t        tbl[15];
    vec_t        v;
    int          checks = 0;
    int          errors = 0;
    int          ack_dly = 1;
    int          req_cycles = 0;
    int          req_total = 0;
    logic [31:0] rdata_cfg = '0;
    logic        ack_r = 1'b0;
    logic [31:0] rdata_r = '0;

    assign bus.dmem_ack   = ack_r;
    assign bus.dmem_rdata = rdata_r;

    // Memory responder: acks in the ack_dly-th request cycle (0 = never)
    always @(negedge clk) begin
        if (bus.dmem_req === 1'b1) begin
            req_cycles++;
            req_total++;
            if (ack_dly != 0 && req_cycles == ack_dly) begin
                ack_r   = 1'b1;
                rdata_r = rdata_cfg;
            end else begin
                ack_r   = 1'b0;
                rdata_r = '0;
            end
        end else begin
            req_cycles = 0;
            ack_r      = 1'b0;
            rdata_r    = '0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    function automatic vec_t blank(input string n);
        vec_t r;
        r.name = n; r.rd = 0; r.wr = 0; r.fp = 0; r.lr = 0; r.sc = 0; r.f3 = F3_W;
        r.addr = '0; r.wdata = '0; r.fpwdata = '0; r.rdata = '0; r.ack_dly = 1;
        r.early = 0; r.exp_mis = 0; r.exp_we = 0; r.exp_be = '0; r.exp_wdata = '0;
        r.exp_stall = 0; r.exp_bus = 0; r.chk_rd = 0; r.chk_fp = 0; r.exp_rd = '0; r.exp_fp = '0;
        return r;
    endfunction

    function automatic vec_t ld(input string n, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] rdata, input int dly, input logic [3:0] be,
                                input logic [31:0] rd_exp);
        vec_t r = blank(n);
        r.rd = 1; r.f3 = f3; r.addr = a; r.rdata = rdata; r.ack_dly = dly; r.exp_be = be;
        r.exp_stall = (dly == 0) ? TO + 1 : dly + 1;
        r.exp_bus = (dly == 0);
        r.chk_rd = 1; r.exp_rd = rd_exp;
        return r;
    endfunction

    function automatic vec_t st(input string n, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be, input logic [31:0] wexp);
        vec_t r = blank(n);
        r.wr = 1; r.f3 = f3; r.addr = a; r.wdata = wd; r.ack_dly = 2;
        r.exp_we = 1; r.exp_be = be; r.exp_wdata = wexp; r.exp_stall = 3;
        return r;
    endfunction

    function automatic vec_t early(input string n, input logic [31:0] a, input logic mis,
                                   input logic [31:0] rd_exp);
        vec_t r = blank(n);
        r.addr = a; r.early = 1; r.exp_mis = mis; r.chk_rd = !mis; r.exp_rd = rd_exp;
        return r;
    endfunction

    task automatic clear_inputs();
        MemReadM = 0; MemWriteM = 0; FPMemM = 0; LrM = 0; ScM = 0; Funct3M = '0;
        ALU_ResultM = '0; WriteDataM = '0; FP_WriteDataM = '0;
        ResInvalidate = 0; ResInvAddr = '0;
    endtask

    task automatic run_vec(input vec_t t);
        vec_t e;
        int   stalls;
        int   req0;
        bit   seen_req;
        @(negedge clk);
        MemReadM = t.rd; MemWriteM = t.wr; FPMemM = t.fp; LrM = t.lr; ScM = t.sc;
        Funct3M = t.f3; ALU_ResultM = t.addr; WriteDataM = t.wdata; FP_WriteDataM = t.fpwdata;
        ack_dly = t.ack_dly; rdata_cfg = t.rdata;
        exp_q.push_back(t);
        req0 = req_total;
        #1;
        if (t.early) begin
            e = exp_q.pop_front();
            chkb({e.name, "_mis"}, MisalignM, e.exp_mis);
            chkb({e.name, "_stall"}, StallM, 1'b0);
            if (e.chk_rd) chk({e.name, "_rd"}, ReadDataM, e.exp_rd);
            @(negedge clk);
            clear_inputs();
            #1;
            chkb({e.name, "_noreq"}, bus.dmem_req, 1'b0);
            chk({e.name, "_nobus"}, 32'(req_total - req0), 32'd0);
            $display("txn %-12s early mis=%b rd=%08h", e.name, e.exp_mis, ReadDataM);
        end else begin
            chkb({t.name, "_stall0"}, StallM, 1'b1);
            stalls   = 1;
            seen_req = 0;
            for (int c = 0; c < 40 && StallM === 1'b1; c++) begin
                @(negedge clk);
                #1;
                if (bus.dmem_req === 1'b1 && !seen_req) begin
                    seen_req = 1;
                    chk({t.name, "_addr"}, bus.dmem_addr, t.addr & 32'hFFFF_FFFC);
                    chk({t.name, "_be"}, 32'(bus.dmem_be), 32'(t.exp_be));
                    chkb({t.name, "_we"}, bus.dmem_we, t.exp_we);
                    if (t.exp_we) chk({t.name, "_wdata"}, bus.dmem_wdata, t.exp_wdata);
                end
                if (StallM === 1'b1) stalls++;
            end
            e = exp_q.pop_front();
            chkb({e.name, "_done"}, StallM, 1'b0);
            chkb({e.name, "_req_drop"}, bus.dmem_req, 1'b0);
            chk({e.name, "_stalls"}, 32'(stalls), 32'(e.exp_stall));
            chkb({e.name, "_buserr"}, BusErrM, e.exp_bus);
            if (e.chk_rd) chk({e.name, "_rd"}, ReadDataM, e.exp_rd);
            if (e.chk_fp) chk({e.name, "_fp"}, FP_ReadDataM, e.exp_fp);
            $display("txn %-12s stalls=%0d rd=%08h fp=%08h buserr=%b",
                     e.name, stalls, ReadDataM, FP_ReadDataM, BusErrM);
        end
    endtask

    task automatic inv_pulse(input logic [31:0] a);
        @(negedge clk);
        clear_inputs();
        ResInvalidate = 1;
        ResInvAddr    = a;
        @(negedge clk);
        ResInvalidate = 0;
        $display("txn snoop_inv   addr=%08h", a);
    endtask

    function automatic vec_t lr200(input string n);
        vec_t r = ld(n, F3_W, 32'h200, 32'h0000_0077, 1, 4'hF, 32'h77);
        r.rd = 0; r.lr = 1;
        return r;
    endfunction

    function automatic vec_t sc_ok(input string n, input logic [31:0] d);
        vec_t r = st(n, F3_W, 32'h200, d, 4'hF, d);
        r.wr = 0; r.sc = 1; r.chk_rd = 1; r.exp_rd = '0;
        return r;
    endfunction

    function automatic vec_t sc_bad(input string n);
        vec_t r = early(n, 32'h200, 1'b0, 32'd1);
        r.sc = 1; r.wdata = 32'hDEAD_0000;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd", ReadDataM, '0);
        chk("rst_fp", FP_ReadDataM, '0);
        chkb("rst_stall", StallM, 1'b0);
        chkb("rst_mis", MisalignM, 1'b0);
        chkb("rst_buserr", BusErrM, 1'b0);
        chkb("rst_req", bus.dmem_req, 1'b0);
        chkb("rst_we", bus.dmem_we, 1'b0);
        chk("rst_addr", bus.dmem_addr, '0);
        chk("rst_wdata", bus.dmem_wdata, '0);
        chk("rst_be", 32'(bus.dmem_be), '0);
        $display("txn reset       done");
        @(negedge clk);
        rst = 0;

        tbl[0]  = ld("lb_103", F3_B, 32'h103, 32'h80AA_55CC, 3, 4'b1000, 32'hFFFF_FF80);
        tbl[1]  = ld("lbu_103", F3_BU, 32'h103, 32'h80AA_55CC, 1, 4'b1000, 32'h0000_0080);
        tbl[2]  = ld("lh_102", F3_H, 32'h102, 32'h80AA_55CC, 2, 4'b1100, 32'hFFFF_80AA);
        tbl[3]  = ld("lhu_100", F3_HU, 32'h100, 32'h80AA_55CC, 1, 4'b0011, 32'h0000_55CC);
        tbl[4]  = ld("lw_104", F3_W, 32'h104, 32'hDEAD_BEEF, 2, 4'b1111, 32'hDEAD_BEEF);
        tbl[5]  = ld("lb_101", F3_B, 32'h101, 32'h80AA_55CC, 1, 4'b0010, 32'h0000_0055);
        tbl[6]  = st("sh_102", F3_H, 32'h102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        tbl[7]  = st("sb_201", F3_B, 32'h201, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
        tbl[8]  = st("sw_300", F3_W, 32'h300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        tbl[9]  = st("fsw_304", F3_W, 32'h304, 32'h1111_1111, 4'b1111, 32'h3F80_0000);
        tbl[9].fp = 1; tbl[9].fpwdata = 32'h3F80_0000;
        tbl[10] = ld("flw_308", F3_W, 32'h308, 32'h4049_0FDB, 1, 4'b1111, 32'h0);
        tbl[10].fp = 1; tbl[10].chk_fp = 1; tbl[10].exp_fp = 32'h4049_0FDB;
        tbl[11] = early("lw_101", 32'h101, 1'b1, '0); tbl[11].rd = 1; tbl[11].f3 = F3_W;
        tbl[12] = early("lh_103", 32'h103, 1'b1, '0); tbl[12].rd = 1; tbl[12].f3 = F3_H;
        tbl[13] = early("sw_102", 32'h102, 1'b1, '0); tbl[13].wr = 1; tbl[13].f3 = F3_W;
        tbl[14] = ld("lb_timeout", F3_B, 32'h103, 32'h80AA_55CC, 0, 4'b1000, 32'h0);

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        // LR then SC succeeds once; a repeat SC fails without a bus access
        run_vec(lr200("lr_a"));
        run_vec(sc_ok("sc_a_ok", 32'h5555_AAAA));
        run_vec(sc_bad("sc_a_again"));

        // Snoop on the reserved word kills the reservation
        run_vec(lr200("lr_b"));
        inv_pulse(32'h0000_0202);
        run_vec(sc_bad("sc_b_snooped"));

        // Snoop on a neighbouring word leaves it intact
        run_vec(lr200("lr_c"));
        inv_pulse(32'h0000_0204);
        run_vec(sc_ok("sc_c_ok", 32'h0BAD_F00D));

        // Own store to the reserved word kills the reservation
        run_vec(lr200("lr_d"));
        run_vec(st("sw_d_200", F3_W, 32'h200, 32'h1357_9BDF, 4'hF, 32'h1357_9BDF));
        run_vec(sc_bad("sc_d_stored"));

        // Reset in the middle of a request drops dmem_req immediately and clears the reservation
        run_vec(lr200("lr_e"));
        @(negedge clk);
        v = ld("rst_lw", F3_W, 32'h400, '0, 0, 4'hF, '0);
        MemReadM = 1; Funct3M = F3_W; ALU_ResultM = v.addr; ack_dly = 0;
        @(negedge clk);
        #1;
        chkb("rst_mid_req_on", bus.dmem_req, 1'b1);
        clear_inputs();
        rst = 1;
        #1;
        chkb("rst_mid_req_drop", bus.dmem_req, 1'b0);
        chkb("rst_mid_stall", StallM, 1'b0);
        chk("rst_mid_rd", ReadDataM, '0);
        @(negedge clk);
        rst = 0;
        $display("txn rst_mid_req dropped req=%b", bus.dmem_req);
        run_vec(sc_bad("sc_e_after_rst"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
